// File: rtl/mask_stream_ctrl.sv
// mask_stream_ctrl
//   Frame sequencer in front of the 3x3 mask filter core. Upstream pixels are
//   banked in a show-ahead prefetch FIFO. The core is held in reset until
//   PRIME_LEVEL pixels are available, or until the whole frame is in. After
//   that, one pixel is handed to the core on every cycle the core is not busy.
//   Filtered pixels coming back from the core are tagged with row/column.
//   The frame ends after ROWS*COLS outputs.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-low reset
//   start                 begin a frame (only looked at in IDLE)
//   src_valid/ready/data  upstream pixel handshake into the prefetch FIFO
//   core_rst              registered active-high reset to the filter core
//   core_data             FIFO head while feeding, otherwise 0
//   core_busy             low = core takes core_data this cycle
//   core_dout/out_valid   filter core output
//   pix_valid/data/col/row tagged output pixel, one cycle after the core output
//   frame_done            pulse together with the last pix_valid of the frame
//   underrun              sticky: core took a pixel while the FIFO was empty
//   state                 FSM state code
//
// State | meaning
//   IDLE  (0) | core in reset, waiting for start
//   PRIME (1) | core in reset, banking pixels into the FIFO
//   RUN   (2) | core running, FIFO feeds the core
//   DRAIN (3) | every pixel has been fed, collecting the remaining outputs
//   DONE  (4) | last output seen, core back in reset, one cycle only

module mask_stream_ctrl #(
  parameter int DW          = 8,
  parameter int COLS        = 16,
  parameter int ROWS        = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int PRIME_LEVEL = 16,
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             src_valid,
  input  logic [DW-1:0]    src_data,
  output logic             src_ready,
  output logic             core_rst,
  output logic [DW-1:0]    core_data,
  input  logic             core_busy,
  input  logic [DW-1:0]    core_dout,
  input  logic             core_out_valid,
  output logic             pix_valid,
  output logic [DW-1:0]    pix_data,
  output logic [COL_W-1:0] pix_col,
  output logic [ROW_W-1:0] pix_row,
  output logic             frame_done,
  output logic             underrun,
  output logic [2:0]       state
);

  localparam int TOTAL = ROWS * COLS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [FC_W-1:0]  FULL_C  = FC_W'(FIFO_DEPTH);
  localparam logic [FC_W-1:0]  PRIME_C = FC_W'(PRIME_LEVEL);
  localparam logic [COL_W-1:0] COL_END = COL_W'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FC_W-1:0]   fifo_cnt;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  feed_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;

  logic in_window;
  logic push;
  logic feed_slot;
  logic fifo_empty;
  logic pop;
  logic out_beat;

  // src_ready ignores a same-cycle pop, so a full FIFO refuses the beat even
  // when the core drains one entry in that cycle.
  always_comb begin
    in_window  = (state_q == PRIME) || (state_q == RUN);
    src_ready  = in_window && (fifo_cnt < FULL_C) && (in_cnt < TOTAL_C);
    push       = src_valid && src_ready;
    feed_slot  = (state_q == RUN) && !core_busy;
    fifo_empty = (fifo_cnt == '0);
    pop        = feed_slot && !fifo_empty;
    core_data  = pop ? mem[rd_ptr] : '0;
    out_beat   = core_out_valid && ((state_q == RUN) || (state_q == DRAIN));
  end

  assign state = state_q;

  // Storage is not reset; a flush only rewinds the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= src_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      in_cnt     <= '0;
      feed_cnt   <= '0;
      out_cnt    <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      core_rst   <= 1'b1;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_col    <= '0;
      pix_row    <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        in_cnt <= in_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        feed_cnt <= feed_cnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (feed_slot && fifo_empty) begin
        underrun <= 1'b1;
      end

      if (out_beat) begin
        pix_valid <= 1'b1;
        pix_data  <= core_dout;
        pix_col   <= col_cnt;
        pix_row   <= row_cnt;
        out_cnt   <= out_cnt + 1'b1;
        if (col_cnt == COL_END) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          core_rst <= 1'b1;
          if (start) begin
            state_q  <= PRIME;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            in_cnt   <= '0;
            feed_cnt <= '0;
            out_cnt  <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            underrun <= 1'b0;
          end
        end
        PRIME: begin
          // A frame shorter than the prime level still has to start.
          if ((fifo_cnt >= PRIME_C) || (in_cnt == TOTAL_C)) begin
            state_q  <= RUN;
            core_rst <= 1'b0;
          end
        end
        RUN: begin
          if (out_beat && (out_cnt == LAST_C)) begin
            state_q    <= DONE;
            core_rst   <= 1'b1;
            frame_done <= 1'b1;
          end else if (pop && (feed_cnt == LAST_C)) begin
            // Leave on the edge of the last pop so RUN never sees the
            // post-frame empty FIFO and flags a bogus underrun.
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_beat && (out_cnt == LAST_C)) begin
            state_q    <= DONE;
            core_rst   <= 1'b1;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          core_rst <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mask_stream_ctrl.sv
// Bench for mask_stream_ctrl with default parameters (16x16 frame, 32-deep FIFO).
// The core model returns each fed pixel XOR 8'h5A, one cycle after it was fed.
module tb_mask_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       src_valid = 1'b0;
  logic [7:0] src_data = '0;
  logic       src_ready;
  logic       core_rst;
  logic [7:0] core_data;
  logic       core_busy = 1'b0;
  logic [7:0] core_dout = '0;
  logic       core_out_valid = 1'b0;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [3:0] pix_col;
  logic [3:0] pix_row;
  logic       frame_done;
  logic       underrun;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  mask_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .core_rst(core_rst), .core_data(core_data), .core_busy(core_busy),
    .core_dout(core_dout), .core_out_valid(core_out_valid),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_col(pix_col), .pix_row(pix_row),
    .frame_done(frame_done), .underrun(underrun), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_v;
    logic       start_v;
    logic       sv;
    logic       busy;
    logic       cov;
    logic [5:0] exp;   // {state, core_rst, src_ready, pix_valid} after the edge
  } vec_t;

  localparam int NV = 25;
  vec_t tv [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; src_valid = 1'b0; core_busy = 1'b0; core_out_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic run_frame(input int abort_at);
    int src_idx = 0;
    int beats = 0;
    int cyc = 0;
    logic pend_v = 1'b0;
    logic [7:0] pend_d = '0;
    logic finished = 1'b0;
    logic saw_drain = 1'b0;
    logic saw_done = 1'b0;
    start = 1'b1; src_valid = 1'b0; core_busy = 1'b0; core_out_valid = 1'b0;
    step();
    start = 1'b0;
    while (!finished && cyc < 1500) begin
      src_valid      = (src_idx < 256);
      src_data       = 8'(src_idx);
      core_out_valid = pend_v;
      core_dout      = pend_d;
      #1;
      if (state == 3'd3) saw_drain = 1'b1;
      if (frame_done) saw_done = 1'b1;
      if (pix_valid) begin
        check($sformatf("beat%0d", beats), {pix_data, pix_col, pix_row, frame_done},
              {8'(beats) ^ 8'h5A, 4'(beats % 16), 4'(beats / 16), 1'(beats == 255)});
        if (beats == 255) begin
          check("done_state", state, 3'd4);
          finished = 1'b1;
        end
        beats++;
      end else if (frame_done) begin
        check("stray_frame_done", frame_done, 1'b0);
      end
      if (src_valid && src_ready) src_idx++;
      pend_v = (state == 3'd2) && !core_busy;
      pend_d = core_data ^ 8'h5A;
      if (abort_at > 0 && beats == abort_at) begin
        rst = 1'b0; src_valid = 1'b0; core_out_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("abort_outputs", {state, core_rst, src_ready, pix_valid, frame_done},
              {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("abort_fifo_empty", dut.fifo_cnt, 0);
        check("abort_no_done", saw_done, 1'b0);
        step();
        #1;
        check("abort_no_done_after", frame_done, 1'b0);
        return;
      end
      if (!finished) begin
        step();
        cyc++;
      end
    end
    src_valid = 1'b0; core_out_valid = 1'b0;
    check("frame_finished", finished, 1'b1);
    check("frame_src_count", src_idx, 256);
    check("frame_saw_drain", saw_drain, 1'b1);
    check("frame_no_underrun", underrun, 1'b0);
    step();
    #1;
    check("idle_after_frame", {state, core_rst}, {3'd0, 1'b1});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin : main
    int acc = 0;
    int idx = 0;
    int waitc = 0;
    logic hit = 1'b0;

    // reset, IDLE, start, priming with 15 pixels then a pause
    for (int i = 0; i < 3; i++) tv[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {3'd0, 1'b1, 1'b0, 1'b0}};
    tv[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {3'd0, 1'b1, 1'b0, 1'b0}};
    tv[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {3'd0, 1'b1, 1'b0, 1'b0}};
    tv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {3'd1, 1'b1, 1'b1, 1'b0}};
    tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {3'd1, 1'b1, 1'b1, 1'b0}};
    for (int i = 7; i < 22; i++) tv[i] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, {3'd1, 1'b1, 1'b1, 1'b0}};
    tv[22] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, {3'd1, 1'b1, 1'b1, 1'b0}};
    for (int i = 23; i < NV; i++) tv[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {3'd1, 1'b1, 1'b1, 1'b0}};

    for (int i = 0; i < NV; i++) begin
      rst = tv[i].rst_v; start = tv[i].start_v; src_valid = tv[i].sv;
      core_busy = tv[i].busy; core_out_valid = tv[i].cov; core_dout = 8'hEE;
      src_data = 8'h40 + 8'(acc);
      #1;
      if (src_valid && src_ready) acc++;
      step();
      check($sformatf("vec%0d", i), {state, core_rst, src_ready, pix_valid}, tv[i].exp);
    end
    start = 1'b0;

    // 16th pixel releases PRIME
    src_valid = 1'b1; src_data = 8'h40 + 8'(acc); core_busy = 1'b1;
    #1;
    if (src_valid && src_ready) acc++;
    step();
    src_valid = 1'b0;
    check("prime_pixels", acc, 16);
    #1;
    waitc = 0;
    while (state != 3'd2 && waitc < 3) begin
      step(); #1; waitc++;
    end
    check("prime_exit_state", state, 3'd2);
    check("prime_exit_core_rst", core_rst, 1'b0);
    check("busy_core_data", core_data, 8'h00);
    step();
    core_busy = 1'b0;
    #1;
    check("show_ahead_head", core_data, 8'h40);
    step();
    core_busy = 1'b1;

    // starve: 40 pixels, core always hungry
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    idx = 0; hit = 1'b0; core_busy = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      src_valid = (idx < 40); src_data = 8'(idx + 1);
      #1;
      if (underrun) hit = 1'b1;
      else begin
        if (src_valid && src_ready) idx++;
        step();
      end
    end
    check("starve_underrun", underrun, 1'b1);
    check("starve_state", state, 3'd2);
    check("starve_core_data", core_data, 8'h00);
    check("starve_feed_cnt", dut.feed_cnt, 40);
    check("starve_src_count", idx, 40);
    src_valid = 1'b0; core_busy = 1'b1; start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    #1;
    check("underrun_sticky", underrun, 1'b1);
    check("start_ignored_in_run", state, 3'd2);

    // full FIFO with the core stalled
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    acc = 0; hit = 1'b0; core_busy = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      src_valid = 1'b1; src_data = 8'h10 + 8'(acc);
      #1;
      if (!src_ready && state != 3'd0) hit = 1'b1;
      else begin
        if (src_ready) acc++;
        step();
      end
    end
    check("full_count", acc, 32);
    check("full_state", state, 3'd2);
    core_busy = 1'b0;
    #1;
    check("full_ready_with_pop", src_ready, 1'b0);
    check("full_head", core_data, 8'h10);
    step();
    core_busy = 1'b1;
    #1;
    check("ready_after_pop", src_ready, 1'b1);
    core_busy = 1'b0; src_data = 8'h10 + 8'(acc);
    #1;
    check("push_pop_head", core_data, 8'h11);
    if (src_ready) acc++;
    step();
    core_busy = 1'b1; src_data = 8'h10 + 8'(acc);
    #1;
    check("ready_after_push_pop", src_ready, 1'b1);
    if (src_ready) acc++;
    step();
    #1;
    check("refull_ready", src_ready, 1'b0);
    src_valid = 1'b0;

    // nominal frame, abort at out_cnt=100, then a complete frame again
    do_reset();
    run_frame(-1);
    run_frame(100);
    run_frame(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
